// File: rtl/shift_div_pkg.sv
// Shared definitions for the shift-subtract divider: FSM state encoding,
// default operand width and the iteration-counter width helper.
package shift_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/shift_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if no borrow.
module shift_div_step
    import shift_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-2:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The partial remainder entering a step is built from at most WIDTH-1
    // dividend bits, so its MSB is always zero and is not carried in.
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_sh = {rem, dvd_msb};
        trial  = {1'b0, rem_sh} - {1'b0, b};
        q_bit  = ~trial[WIDTH];
        if (trial[WIDTH]) begin
            rem_next = rem_sh;
        end else begin
            rem_next = trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shift_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Optional SHIFT_DIV_DBZ_EN: divide-by-zero early exit with dbz flag.
module shift_div
    import shift_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SHIFT_DIV_DBZ_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;

    shift_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .b        (b_q),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
`ifdef SHIFT_DIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT_DIV_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
`ifdef SHIFT_DIV_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = a;
                    rem_d   = '0;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SHIFT_DIV_DBZ_EN
                    dbz_d   = 1'b0;
                    if (b == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                rem_d = rem_nx[WIDTH-2:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    q_d     = {dvd_q[WIDTH-2:0], q_bit};
                    r_d     = rem_nx;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign q    = q_q;
    assign r    = r_q;
`ifdef SHIFT_DIV_DBZ_EN
    assign dbz  = dbz_q;
`else
    assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_div.sv
// Self-checking bench for shift_div: directed vector table, hand-written
// back-to-back and mid-operation reset sequences, and a random sweep.
module tb_shift_div;

    localparam int W = 8;
`ifdef SHIFT_DIV_DBZ_EN
    localparam int   ZLAT = 1;
    localparam logic ZDBZ = 1'b1;
`else
    localparam int   ZLAT = W + 1;
    localparam logic ZDBZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dbz;
    logic [W-1:0] q, r;

    shift_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse consumes the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                chk("q", 32'(q), 32'(mon_e.q));
                chk("r", 32'(r), 32'(mon_e.r));
                chk("dbz", 32'(dbz), 32'(mon_e.dbz));
                chk("busy_during_done", 32'(busy), 32'd0);
                if (mon_e.b != '0) begin
                    chk("q*b+r==a", 32'(q) * 32'(mon_e.b) + 32'(r), 32'(mon_e.a));
                    chk("r<b", 32'(r < mon_e.b), 32'd1);
                end
            end
        end
    end

    // Drive one operation, then measure latency and busy length until done.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [W-1:0] qe, input logic [W-1:0] re,
                         input logic de, input int lat_e);
        int cyc;
        int bcnt;
        @(negedge clk);
        a = ai;
        b = bi;
        start = 1'b1;
        sb.push_back('{ai, bi, qe, re, de});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat_e));
        chk("busy_cycles", 32'(bcnt), 32'(lat_e - 1));
    endtask

    vec_t vecs[9];

    initial begin
        logic [W-1:0] ra, rb;
        int cyc;

        vecs[0] = '{8'hFF, 8'h80, 8'h01, 8'h7F, 1'b0, W + 1};
        vecs[1] = '{8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W + 1};
        vecs[2] = '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0, W + 1};
        vecs[3] = '{8'd0, 8'd1, 8'd0, 8'd0, 1'b0, W + 1};
        vecs[4] = '{8'd12, 8'd0, 8'hFF, 8'd12, ZDBZ, ZLAT};
        vecs[5] = '{8'hFF, 8'hFF, 8'd1, 8'd0, 1'b0, W + 1};
        vecs[6] = '{8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0, W + 1};
        vecs[7] = '{8'd1, 8'hFF, 8'd0, 8'd1, 1'b0, W + 1};
        vecs[8] = '{8'd129, 8'd2, 8'd64, 8'd1, 1'b0, W + 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        // Results hold after done while idle
        repeat (3) @(negedge clk);
        chk("q_hold_idle", 32'(q), 32'd64);
        chk("r_hold_idle", 32'(r), 32'd1);

        // Start held high: second request ignored during RUN, taken in done cycle
        @(negedge clk);
        a = 8'd100;
        b = 8'd3;
        start = 1'b1;
        sb.push_back('{8'd100, 8'd3, 8'd33, 8'd1, 1'b0});
        cyc = 0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        a = 8'd50;
        b = 8'd5;
        sb.push_back('{8'd50, 8'd5, 8'd10, 8'd0, 1'b0});
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", 32'(cyc), 32'(W + 1));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_gap_busy", 32'(busy), 32'd1);
        chk("q_held_during_run", 32'(q), 32'd33);
        chk("r_held_during_run", 32'(r), 32'd1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_second_latency", 32'(cyc), 32'(W + 1));

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 8'd200;
        b = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_r", 32'(r), 32'd0);
        chk("arst_dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        chk("arst_held_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        do_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W + 1);

        // Random sweep against the bench's own division
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            do_op(ra, rb, ra / rb, ra % rb, 1'b0, W + 1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
